// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: DATA_W-bit frames, sclk = clk / (2*CLK_DIV), selectable bit order.
// Define SPI_MISO_RX_EN to add MISO capture (miso, dout, dout_valid).
module spi_master_tx #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dv,
  input  logic [DATA_W-1:0] din,
`ifdef SPI_MISO_RX_EN
  input  logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
`endif
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              ss
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                ready_q, done_q, sclk_q, mosi_q, ss_q;
  logic                div_wrap;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  // Consume the bit just driven so the next one sits where first_bit looks.
  function automatic logic [DATA_W-1:0] consume(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign div_wrap = (div_q == DIV_LAST);
  assign div_d    = div_wrap ? '0 : div_q + 1'b1;

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] rx_q, dout_q;
  logic              dout_valid_q;

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (state_q == SHIFT && div_wrap && !sclk_q)
        rx_q <= rx_insert(rx_q, miso);
      if (state_q == TRAIL && div_wrap) begin
        dout_q       <= rx_q;
        dout_valid_q <= 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dv) begin
            shreg_q   <= consume(din);
            mosi_q    <= first_bit(din);
            ss_q      <= 1'b0;
            ready_q   <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          div_q <= div_d;
          if (div_wrap) begin
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              // Last falling edge leaves mosi on the final bit through the hold time.
              if (bit_cnt_q == CNT_LAST) begin
                state_q <= TRAIL;
              end else begin
                mosi_q  <= first_bit(shreg_q);
                shreg_q <= consume(shreg_q);
              end
            end
          end
        end
        TRAIL: begin
          div_q <= div_d;
          if (div_wrap) begin
            ss_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
            mosi_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign ss    = ss_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: an LSB-first and an MSB-first instance checked every cycle against a
// frame-offset model, plus literal expectations for the directed scenarios.
module tb_spi_master_tx;
  localparam int DW    = 8;
  localparam int CD    = 2;
  localparam int FRAME = (2 * DW + 1) * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dv  = 2'b00;
  logic [7:0] din [2];
  logic [1:0] ready, done, sclk, mosi, ss;
`ifdef SPI_MISO_RX_EN
  logic [7:0] dout [2];
  logic [1:0] dout_valid;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(CD), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .dv(dv[0]), .din(din[0]),
`ifdef SPI_MISO_RX_EN
    .miso(mosi[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
`endif
    .ready(ready[0]), .done(done[0]), .sclk(sclk[0]), .mosi(mosi[0]), .ss(ss[0])
  );

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(CD), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .dv(dv[1]), .din(din[1]),
`ifdef SPI_MISO_RX_EN
    .miso(mosi[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
`endif
    .ready(ready[1]), .done(done[1]), .sclk(sclk[1]), .mosi(mosi[1]), .ss(ss[1])
  );

  // Model: m = edges since acceptance; outputs follow from the frame timing rules.
  int         m    [2] = '{-1, -1};
  bit         busy [2] = '{1'b0, 1'b0};
  logic [7:0] w    [2] = '{8'h00, 8'h00};
  logic [7:0] dexp [2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 1'b0; m[i] = -1; dexp[i] = 8'h00;
      end else if (busy[i]) begin
        m[i]++;
        if (m[i] == FRAME) begin busy[i] = 1'b0; dexp[i] = w[i]; end
      end else if (dv[i]) begin
        busy[i] = 1'b1; m[i] = 0; w[i] = din[i];
      end else begin
        m[i] = -1;
      end
    end
  end

  // Literal expectations posted by the stimulus, evaluated by the compare process.
  string lit_nm  [64];
  int    lit_act [64];
  int    lit_exp [64];
  int    lit_wr = 0;
  int    lit_rd = 0;

  task automatic lit(input string nm, input int act, input int exp);
    lit_nm[lit_wr] = nm; lit_act[lit_wr] = act; lit_exp[lit_wr] = exp;
    lit_wr++;
  endtask

  int         rises [2] = '{0, 0};
  int         dones [2] = '{0, 0};
  int         sslow [2] = '{0, 0};
  int         hr    [2] = '{0, 0};
  int         gap   [2] = '{0, 0};
  logic [7:0] seq   [2] = '{8'h00, 8'h00};
  logic [1:0] sclk_prev = 2'b00;
  logic [1:0] ss_prev   = 2'b11;

  always @(negedge clk) begin
    logic e_ss, e_sclk, e_mosi, e_ready, e_done;
    int j;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          e_ss = 1'b0; e_ready = 1'b0; e_done = 1'b0;
          e_sclk = (m[i] < 2 * DW * CD) && ((m[i] / CD) % 2 == 1);
          j = m[i] / (2 * CD);
          if (j > DW - 1) j = DW - 1;
          e_mosi = (i == 0) ? w[i][j] : w[i][DW-1-j];
        end else begin
          e_ss = 1'b1; e_ready = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
          e_done = (m[i] == FRAME);
        end
        checks++;
        if ({ss[i], sclk[i], mosi[i], ready[i], done[i]} !== {e_ss, e_sclk, e_mosi, e_ready, e_done}) begin
          failures++;
          $display("FAIL model_outs inst=%0d t=%0t ss/sclk/mosi/ready/done actual=%b%b%b%b%b required=%b%b%b%b%b",
                   i, $time, ss[i], sclk[i], mosi[i], ready[i], done[i], e_ss, e_sclk, e_mosi, e_ready, e_done);
        end
`ifdef SPI_MISO_RX_EN
        checks++;
        if ({dout[i], dout_valid[i]} !== {dexp[i], e_done}) begin
          failures++;
          $display("FAIL model_rx inst=%0d t=%0t dout/valid actual=%h/%b required=%h/%b",
                   i, $time, dout[i], dout_valid[i], dexp[i], e_done);
        end
`endif
        if (sclk[i] && !sclk_prev[i]) begin
          rises[i]++;
          seq[i] = (i == 0) ? {mosi[i], seq[i][7:1]} : {seq[i][6:0], mosi[i]};
        end
        if (done[i]) dones[i]++;
        if (!ss[i]) sslow[i]++;
        if (ss[i]) hr[i]++;
        if (!ss[i] && ss_prev[i]) begin gap[i] = hr[i]; hr[i] = 0; end
      end
      sclk_prev = sclk;
      ss_prev   = ss;
      while (lit_rd < lit_wr) begin
        checks++;
        if (lit_act[lit_rd] != lit_exp[lit_rd]) begin
          failures++;
          $display("FAIL %s actual=%0h required=%0h", lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
        end
        lit_rd++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int i, input int max);
    int n = 0;
    while (!done[i] && n < max) begin @(posedge clk); #1; n++; end
    lit($sformatf("done_seen_inst%0d", i), int'(done[i]), 1);
  endtask

  task automatic pulse(input int i, input logic [7:0] d);
    din[i] = d; dv[i] = 1'b1;
    cyc(1);
    dv[i] = 1'b0;
  endtask

  initial begin
    int d0, d1, s0, s1, r0, r1, n;
    din[0] = 8'h00; din[1] = 8'h00;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    rst = 1'b0;

    // Idle after reset
    d0 = dones[0] + dones[1]; s0 = sslow[0] + sslow[1];
    cyc(10);
    lit("idle_outs", int'({ss, sclk, mosi, ready, done}), 'b11_00_00_11_00);
    lit("idle_done_count", dones[0] + dones[1] - d0, 0);
    lit("idle_ss_low_count", sslow[0] + sslow[1] - s0, 0);

    // LSB-first single frame 0xA5
    d0 = dones[0]; s0 = sslow[0]; r0 = rises[0];
    pulse(0, 8'hA5);
    wait_done(0, 100);
    cyc(2);
    lit("lsb_a5_bits", int'(seq[0]), 'hA5);
    lit("lsb_a5_rises", rises[0] - r0, 8);
    lit("lsb_a5_ss_low", sslow[0] - s0, 34);
    lit("lsb_a5_dones", dones[0] - d0, 1);

    // MSB-first back-to-back 0xA5 then 0x3C with dv held
    d1 = dones[1]; s1 = sslow[1]; r1 = rises[1];
    din[1] = 8'hA5; dv[1] = 1'b1;
    cyc(1);
    din[1] = 8'h3C;
    wait_done(1, 100);
    lit("msb_a5_bits", int'(seq[1]), 'hA5);
    n = 0;
    while (ready[1] && n < 5) begin cyc(1); n++; end
    lit("msb_second_accept", int'(ready[1]), 0);
    dv[1] = 1'b0;
    wait_done(1, 100);
    cyc(2);
    lit("msb_3c_bits", int'(seq[1]), 'h3C);
    lit("msb_gap", gap[1], 1);
    lit("msb_rises", rises[1] - r1, 16);
    lit("msb_ss_low", sslow[1] - s1, 68);
    lit("msb_dones", dones[1] - d1, 2);

    // dv with 0xFF mid-frame ignored
    d0 = dones[0]; r0 = rises[0];
    pulse(0, 8'h00);
    cyc(10);
    pulse(0, 8'hFF);
    wait_done(0, 100);
    cyc(40);
    lit("ignore_bits", int'(seq[0]), 'h00);
    lit("ignore_rises", rises[0] - r0, 8);
    lit("ignore_dones", dones[0] - d0, 1);

    // Reset on the 4th rising sclk edge
    d0 = dones[0]; r0 = rises[0];
    pulse(0, 8'hA5);
    cyc(13);
    lit("pre_abort_sclk", int'(sclk[0]), 0);
    rst = 1'b1;
    cyc(1);
    lit("abort_ss_sclk_ready_done", int'({ss[0], sclk[0], ready[0], done[0]}), 'b1010);
    rst = 1'b0;
    cyc(40);
    lit("abort_no_done", dones[0] - d0, 0);
    lit("abort_rises", rises[0] - r0, 3);

    // Clean frame after abort, 0x5A (loopback capture when enabled)
    d0 = dones[0];
    pulse(0, 8'h5A);
    wait_done(0, 100);
`ifdef SPI_MISO_RX_EN
    lit("rx_dout", int'(dout[0]), 'h5A);
    lit("rx_dout_valid", int'(dout_valid[0]), 1);
`endif
    cyc(2);
    lit("post_abort_bits", int'(seq[0]), 'h5A);
    lit("post_abort_dones", dones[0] - d0, 1);

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Parametrised SPI master (mode 0) serialising DATA_W-bit words onto mosi.
- Generates sclk and active-low ss.
- Next generation of the single-byte SSI transmitter: adds configurable width, clock divider, bit order, a ready/done handshake and optional MISO capture.
- Sits between an on-chip producer (FIFO or register block) and an external SPI slave.

Parameters:
- DATA_W, 8: bits per frame; must be >= 2.
- CLK_DIV, 2: clk cycles per sclk half-period; must be >= 1.
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = bit DATA_W-1 first.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- dv  in  1  input word valid.
- din  in  DATA_W  word to transmit; sampled when dv && ready.
- ready  out  1  block idle, can accept a word.
- done  out  1  one-cycle pulse at frame end.
- sclk  out  1  SPI clock, idle low (CPOL=0).
- mosi  out  1  serial data; changes on sclk falling edge or frame start (CPHA=0).
- ss  out  1  slave select, active-low.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - On a clk edge with rst=1: state=IDLE, ss=1, sclk=0, mosi=0, ready=1, done=0, bit counter=0, divider=0, shift register=0.
- States: IDLE, SHIFT, TRAIL.
- IDLE:
  - ready=1, ss=1, sclk=0.
  - On dv=1 (accept at edge t0): latch din into the shift register; go to SHIFT.
  - At t1 = t0+1: ss=0, sclk=0, mosi=first bit, ready=0.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. At wrap, sclk toggles.
  - sclk rises at t1+CLK_DIV*(2k+1) and falls at t1+CLK_DIV*(2k+2), for k = 0..DATA_W-1.
  - On each falling edge except the last: mosi updates to the next bit, in the order set by LSB_FIRST.
  - After the DATA_W-th falling edge: go to TRAIL. mosi holds the last bit; sclk=0.
- TRAIL:
  - ss stays low for CLK_DIV further cycles (hold time).
  - Then at t_end = t1+(2*DATA_W+1)*CLK_DIV: ss=1, ready=1, done=1 for exactly one cycle, mosi=0, state=IDLE.
- Frame length: ss is low for (2*DATA_W+1)*CLK_DIV cycles. For DATA_W=8, CLK_DIV=2 this is 34.
- Handshake:
  - dv is ignored while ready=0; no queuing, din changes mid-frame have no effect.
  - Producer holds dv until it sees ready.
- Back-to-back: dv=1 in the cycle ready returns to 1 is accepted at that edge. ss is then high for exactly one cycle between frames (minimum deassert time).
- Reset mid-frame: the frame is abandoned. On the next edge all outputs return to reset values; no done pulse.
- Counters: the bit counter is $clog2(DATA_W+1) bits wide; no wrap beyond DATA_W. The divider is $clog2(CLK_DIV) bits wide, or 1 bit when CLK_DIV=1. With CLK_DIV=1, sclk = clk/2.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SPI_MISO_RX_EN.
- When defined, these ports are added:
  - miso  in  1  serial input from the slave.
  - dout  out  DATA_W  captured word.
  - dout_valid  out  1.
- With the feature:
  - miso is sampled on each sclk rising edge, in the same bit order as transmit.
  - dout updates at t_end; dout_valid pulses together with done.
  - dout resets to 0 and holds its value between frames.
  - An aborted frame (reset) does not update dout.
- Without it: the ports are absent, there is no capture logic, and transmit behaviour is identical.

Test Plan:
- Reset then idle 10 cycles -> ss=1, sclk=0, mosi=0, ready=1, done=0 throughout.
- DATA_W=8, CLK_DIV=2, LSB_FIRST=1, din=0xA5 with 1-cycle dv -> mosi on the 8 sclk rising edges = 1,0,1,0,0,1,0,1. ss low 34 cycles; one done pulse as ss rises.
- LSB_FIRST=0, din=0xA5 -> rising-edge bits 1,0,1,0,0,1,0,1 in MSB order (word 0xA5 reconstructed MSB-first). Second word 0x3C sent with dv held continuously -> ss high exactly 1 cycle between frames, then 0,0,1,1,1,1,0,0.
- dv=1 with din=0xFF pulsed mid-frame while sending 0x00 -> ignored; mosi stays 0 for all bits; exactly one done.
- rst=1 at the 4th sclk rising edge of a frame -> next cycle ss=1, sclk=0, ready=1; no done pulse; a new frame starts cleanly afterwards.
- SPI_MISO_RX_EN defined, miso looped to mosi, din=0x5A -> dout=0x5A with dout_valid coincident with done.
